shiftreg_bidir_seq: RTL and testbench

Parametrised successor to the 4-bit bidirectional shift register, with configurable WIDTH.
- Keeps parallel load, serial in and left/right direction.
- Adds a multi-bit shift sequencer: one Start command shifts Amt positions, one bit per clock.
- Adds a Busy/Done handshake and a registered serial output for chaining.
- Sits between datapath registers and serial links that need counted shifts.

---
 rtl/shiftreg_bidir_seq.sv | 109 ++++++++++
 tb/tb_shiftreg_bidir_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/shiftreg_bidir_seq.sv
// WIDTH-bit bidirectional shift register with parallel load and a counted shift sequencer (Busy/Done).
// Optional rotate mode enabled by defining SHIFTREG_ROTATE_EN.
module shiftreg_bidir_seq #(
    parameter int WIDTH = 4,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             LD,
    input  logic [WIDTH-1:0] InP,
    input  logic             InS,
    input  logic             RL,
    input  logic             Rot,
    input  logic             Start,
    input  logic [AW-1:0]    Amt,
    output logic [WIDTH-1:0] D,
    output logic             OutS,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic             outs_nxt, done_nxt;
    logic [AW-1:0]    count, count_nxt, amt_sat;
    logic             dir, dir_nxt;
    logic             fill_in, fill_in_nxt;
    logic             rot, rot_nxt;
    logic             out_bit, fill;

    assign amt_sat = (Amt > AW'(WIDTH)) ? AW'(WIDTH) : Amt;
    assign out_bit = dir ? D[WIDTH-1] : D[0];

`ifdef SHIFTREG_ROTATE_EN
    assign fill = rot ? out_bit : fill_in;
`else
    // Rot is still latched so both builds share one register map; it just never steers the fill.
    logic unused_rot;
    assign unused_rot = rot;
    assign fill       = fill_in;
`endif

    assign Busy = (state == SHIFT);

    always_comb begin
        state_nxt   = state;
        d_nxt       = D;
        outs_nxt    = OutS;
        done_nxt    = 1'b0;
        count_nxt   = count;
        dir_nxt     = dir;
        fill_in_nxt = fill_in;
        rot_nxt     = rot;
        if (LD) begin
            // a load also aborts any sequence in flight, without a Done pulse
            d_nxt     = InP;
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        dir_nxt     = RL;
                        fill_in_nxt = InS;
                        rot_nxt     = Rot;
                        count_nxt   = amt_sat;
                        if (amt_sat == '0) done_nxt  = 1'b1;
                        else               state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    d_nxt     = dir ? {D[WIDTH-2:0], fill} : {fill, D[WIDTH-1:1]};
                    outs_nxt  = out_bit;
                    count_nxt = count - AW'(1);
                    if (count == AW'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Clear) begin
            state   <= IDLE;
            D       <= '0;
            OutS    <= 1'b0;
            Done    <= 1'b0;
            count   <= '0;
            dir     <= 1'b0;
            fill_in <= 1'b0;
            rot     <= 1'b0;
        end else begin
            state   <= state_nxt;
            D       <= d_nxt;
            OutS    <= outs_nxt;
            Done    <= done_nxt;
            count   <= count_nxt;
            dir     <= dir_nxt;
            fill_in <= fill_in_nxt;
            rot     <= rot_nxt;
        end
    end

endmodule

// File: tb/tb_shiftreg_bidir_seq.sv
// Self-checking bench for shiftreg_bidir_seq (WIDTH=8): directed scenarios then random stimulus vs a queue-based model.
module tb_shiftreg_bidir_seq;
    localparam int W   = 8;
    localparam int AWT = $clog2(W) + 1;

    logic           CLK = 1'b0;
    logic           Clear = 1'b0, LD = 1'b0, InS = 1'b0, RL = 1'b0, Rot = 1'b0, Start = 1'b0;
    logic [W-1:0]   InP = '0;
    logic [AWT-1:0] Amt = '0;
    logic [W-1:0]   D;
    logic           OutS, Busy, Done;

    shiftreg_bidir_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .Clear(Clear), .LD(LD), .InP(InP), .InS(InS), .RL(RL), .Rot(Rot),
        .Start(Start), .Amt(Amt), .D(D), .OutS(OutS), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // model: register value plus a queue of the {OutS, D} results still to come from a pending sequence
    logic [W-1:0] m_d    = '0;
    logic         m_outs = 1'b0;
    logic         m_done = 1'b0;
    logic [W:0]   plan[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic build_plan(input int n, input bit left, input bit ins, input bit r);
        logic [W-1:0] d;
        logic         ob, f;
        d = m_d;
        for (int i = 0; i < n; i++) begin
            ob = left ? d[W-1] : d[0];
            f  = ins;
`ifdef SHIFTREG_ROTATE_EN
            if (r) f = ob;
`endif
            if (left) d = W'((d << 1) | W'(f));
            else      d = W'((d >> 1) | (W'(f) << (W-1)));
            plan.push_back({ob, d});
        end
    endtask

    task automatic model_edge();
        logic [W:0] e;
        int         n;
        m_done = 1'b0;
        if (Clear) begin
            m_d = '0; m_outs = 1'b0; plan.delete();
        end else if (LD) begin
            m_d = InP; plan.delete();
        end else if (plan.size() != 0) begin
            e      = plan.pop_front();
            m_d    = e[W-1:0];
            m_outs = e[W];
            m_done = (plan.size() == 0);
        end else if (Start) begin
            n = (int'(Amt) > W) ? W : int'(Amt);
            if (n == 0) m_done = 1'b1;
            else        build_plan(n, RL, InS, Rot);
        end
    endtask

    task automatic cyc(input logic clr, input logic ld, input logic [W-1:0] inp, input logic ins,
                       input logic rl, input logic rot, input logic st, input logic [AWT-1:0] amt);
        Clear = clr; LD = ld; InP = inp; InS = ins; RL = rl; Rot = rot; Start = st; Amt = amt;
        @(posedge CLK);
        model_edge();
        #1;
        check("d",    32'(D),    32'(m_d));
        check("outs", 32'(OutS), 32'(m_outs));
        check("busy", 32'(Busy), 32'(plan.size() != 0));
        check("done", 32'(Done), 32'(m_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, AWT'($urandom));
    endtask

    initial begin
        // reset overrides load and start
        cyc(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
        cyc(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
        check("rst_d", 32'(D), 32'h00);

        cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("load_d", 32'(D), 32'hA5);

        // left shift by 3 with fill 1
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
        idle(1); check("l3_1", 32'(D), 32'h4B);
        idle(1); check("l3_2", 32'(D), 32'h97);
        idle(1); check("l3_3", 32'(D), 32'h2F);
        check("l3_done", 32'(Done), 32'h1);
        idle(2);

        // right shift by 2 with fill 0, then zero count, then clamped count
        cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        idle(2); check("r2_d", 32'(D), 32'h29);
        idle(1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("z_done", 32'(Done), 32'h1);
        idle(1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
        idle(8); check("clamp_d", 32'(D), 32'h00);
        idle(2);

        // load aborts mid-sequence, then clear aborts mid-sequence
        cyc(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
        idle(1);
        cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        check("ab_ld_d", 32'(D), 32'h3C);
        idle(3);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
        idle(1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        check("ab_clr_d", 32'(D), 32'h00);
        idle(3);

        // rotate-select right by 1
        cyc(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
        idle(1);
`ifdef SHIFTREG_ROTATE_EN
        check("rot_d", 32'(D), 32'hC0);
`else
        check("rot_d", 32'(D), 32'h40);
`endif
        check("rot_outs", 32'(OutS), 32'h1);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 11) == 0), W'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                AWT'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
